// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register that presents forwarded ALU operands under a valid/ready handshake.
// Define FWD_EN to resolve RAW hazards by bypass. The default build stalls until the writer retires.
module id_ex_operand_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    id_aluop,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_wsel,
  input  logic [DW-1:0] id_rdat1,
  input  logic [DW-1:0] id_rdat2,
  input  logic [DW-1:0] id_imm,
  input  logic          id_alusrc,
  input  logic          id_regwen,
  input  logic          id_memrd,
  output logic          ex_valid,
  input  logic          ex_ready,
  output logic [DW-1:0] port_a,
  output logic [DW-1:0] port_b,
  output logic [3:0]    ex_aluop,
  output logic [RW-1:0] ex_wsel,
  output logic          ex_regwen,
  output logic          ex_memrd,
  output logic [DW-1:0] ex_rt_dat,
  input  logic          exmem_regwen,
  input  logic          exmem_memrd,
  input  logic [RW-1:0] exmem_wsel,
  input  logic [DW-1:0] exmem_wdat,
  input  logic          memwb_regwen,
  input  logic [RW-1:0] memwb_wsel,
  input  logic [DW-1:0] memwb_wdat
);

  logic          valid_q, valid_d;
  logic [3:0]    aluop_q, aluop_d;
  logic [RW-1:0] rs_q, rs_d;
  logic [RW-1:0] rt_q, rt_d;
  logic [RW-1:0] wsel_q, wsel_d;
  logic [DW-1:0] rdat1_q, rdat1_d;
  logic [DW-1:0] rdat2_q, rdat2_d;
  logic [DW-1:0] imm_q, imm_d;
  logic          alusrc_q, alusrc_d;
  logic          regwen_q, regwen_d;
  logic          memrd_q, memrd_d;

  logic          rt_used;
  logic          exmem_rs_hit, exmem_rt_hit;
  logic          memwb_rs_hit, memwb_rt_hit;
  logic          hazard;
  logic          fire;
  logic          accept;
  logic [DW-1:0] rs_op, rt_op;

  // A load with an immediate address never reads rt, so only that case frees rt.
  assign rt_used = !alusrc_q || !memrd_q;

  assign exmem_rs_hit = exmem_regwen && (exmem_wsel == rs_q) && (rs_q != '0);
  assign exmem_rt_hit = exmem_regwen && (exmem_wsel == rt_q) && (rt_q != '0);
  assign memwb_rs_hit = memwb_regwen && (memwb_wsel == rs_q) && (rs_q != '0);
  assign memwb_rt_hit = memwb_regwen && (memwb_wsel == rt_q) && (rt_q != '0);

`ifdef FWD_EN
  assign rs_op = exmem_rs_hit ? exmem_wdat : (memwb_rs_hit ? memwb_wdat : rdat1_q);
  assign rt_op = exmem_rt_hit ? exmem_wdat : (memwb_rt_hit ? memwb_wdat : rdat2_q);

  // Load data is not ready until MEM/WB, so a load-use costs exactly one bubble.
  assign hazard = valid_q && exmem_memrd &&
                  (exmem_rs_hit || (rt_used && exmem_rt_hit));
`else
  logic unused_fwd;

  assign rs_op  = rdat1_q;
  assign rt_op  = rdat2_q;
  assign hazard = valid_q &&
                  (exmem_rs_hit || memwb_rs_hit ||
                   (rt_used && (exmem_rt_hit || memwb_rt_hit)));
  assign unused_fwd = ^{exmem_memrd, exmem_wdat, memwb_wdat};
`endif

  assign ex_valid  = valid_q && !hazard;
  assign fire      = ex_valid && ex_ready;
  assign in_ready  = !valid_q || fire;
  assign accept    = in_valid && in_ready && !flush;

  assign port_a    = rs_op;
  assign port_b    = alusrc_q ? imm_q : rt_op;
  assign ex_rt_dat = rt_op;
  assign ex_aluop  = aluop_q;
  assign ex_wsel   = wsel_q;
  assign ex_regwen = ex_valid && regwen_q;
  assign ex_memrd  = ex_valid && memrd_q;

  always_comb begin
    // NOTE: every _d starts as its _q so no path through this block infers a latch.
    valid_d  = valid_q;
    aluop_d  = aluop_q;
    rs_d     = rs_q;
    rt_d     = rt_q;
    wsel_d   = wsel_q;
    rdat1_d  = rdat1_q;
    rdat2_d  = rdat2_q;
    imm_d    = imm_q;
    alusrc_d = alusrc_q;
    regwen_d = regwen_q;
    memrd_d  = memrd_q;

    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d  = 1'b1;
      aluop_d  = id_aluop;
      rs_d     = id_rs;
      rt_d     = id_rt;
      wsel_d   = id_wsel;
      rdat1_d  = id_rdat1;
      rdat2_d  = id_rdat2;
      imm_d    = id_imm;
      alusrc_d = id_alusrc;
      regwen_d = id_regwen;
      memrd_d  = id_memrd;
    end else if (fire) begin
      valid_d = 1'b0;
    end
`ifndef FWD_EN
    // The register file writes in the first half-cycle, so re-reading picks up the retiring value.
    else if (hazard) begin
      rdat1_d = id_rdat1;
      rdat2_d = id_rdat2;
    end
`endif
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q  <= 1'b0;
      aluop_q  <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      wsel_q   <= '0;
      rdat1_q  <= '0;
      rdat2_q  <= '0;
      imm_q    <= '0;
      alusrc_q <= 1'b0;
      regwen_q <= 1'b0;
      memrd_q  <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      aluop_q  <= aluop_d;
      rs_q     <= rs_d;
      rt_q     <= rt_d;
      wsel_q   <= wsel_d;
      rdat1_q  <= rdat1_d;
      rdat2_q  <= rdat2_d;
      imm_q    <= imm_d;
      alusrc_q <= alusrc_d;
      regwen_q <= regwen_d;
      memrd_q  <= memrd_d;
    end
  end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Scoreboard bench for id_ex_operand_stage: expected ALU operands are queued when an
// instruction is driven and compared when the stage fires. Covers both FWD_EN builds.
module tb_id_ex_operand_stage;

  localparam int DW = 32;
  localparam int RW = 5;

  typedef struct {
    logic [3:0]    aluop;
    logic [RW-1:0] rs, rt, wsel;
    logic [DW-1:0] rdat1, rdat2, imm;
    logic          alusrc, regwen, memrd;
  } instr_t;

  typedef struct {
    logic [3:0]    aluop;
    logic [RW-1:0] wsel;
    logic          regwen, memrd;
    logic [DW-1:0] port_a, port_b, rt_dat;
  } exp_t;

  logic          CLK = 1'b0;
  logic          nRST = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    id_aluop = '0;
  logic [RW-1:0] id_rs = '0, id_rt = '0, id_wsel = '0;
  logic [DW-1:0] id_rdat1 = '0, id_rdat2 = '0, id_imm = '0;
  logic          id_alusrc = 1'b0, id_regwen = 1'b0, id_memrd = 1'b0;
  logic          ex_valid;
  logic          ex_ready = 1'b0;
  logic [DW-1:0] port_a, port_b, ex_rt_dat;
  logic [3:0]    ex_aluop;
  logic [RW-1:0] ex_wsel;
  logic          ex_regwen, ex_memrd;
  logic          exmem_regwen = 1'b0, exmem_memrd = 1'b0;
  logic [RW-1:0] exmem_wsel = '0;
  logic [DW-1:0] exmem_wdat = '0;
  logic          memwb_regwen = 1'b0;
  logic [RW-1:0] memwb_wsel = '0;
  logic [DW-1:0] memwb_wdat = '0;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];
  exp_t mon_e;

  id_ex_operand_stage #(.DW(DW), .RW(RW)) dut (
    .CLK(CLK), .nRST(nRST), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .id_aluop(id_aluop), .id_rs(id_rs), .id_rt(id_rt), .id_wsel(id_wsel),
    .id_rdat1(id_rdat1), .id_rdat2(id_rdat2), .id_imm(id_imm),
    .id_alusrc(id_alusrc), .id_regwen(id_regwen), .id_memrd(id_memrd),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .port_a(port_a), .port_b(port_b), .ex_aluop(ex_aluop), .ex_wsel(ex_wsel),
    .ex_regwen(ex_regwen), .ex_memrd(ex_memrd), .ex_rt_dat(ex_rt_dat),
    .exmem_regwen(exmem_regwen), .exmem_memrd(exmem_memrd),
    .exmem_wsel(exmem_wsel), .exmem_wdat(exmem_wdat),
    .memwb_regwen(memwb_regwen), .memwb_wsel(memwb_wsel), .memwb_wdat(memwb_wdat)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic instr_t mk(input logic [3:0] aluop, input logic [RW-1:0] rs,
                                input logic [RW-1:0] rt, input logic [RW-1:0] wsel,
                                input logic [DW-1:0] rdat1, input logic [DW-1:0] rdat2,
                                input logic [DW-1:0] imm, input logic alusrc,
                                input logic regwen, input logic memrd);
    instr_t i;
    i.aluop = aluop; i.rs = rs; i.rt = rt; i.wsel = wsel;
    i.rdat1 = rdat1; i.rdat2 = rdat2; i.imm = imm;
    i.alusrc = alusrc; i.regwen = regwen; i.memrd = memrd;
    return i;
  endfunction

  // Expected outputs when nothing is bypassed.
  function automatic exp_t plain(input instr_t i);
    exp_t e;
    e.aluop  = i.aluop;
    e.wsel   = i.wsel;
    e.regwen = i.regwen;
    e.memrd  = i.memrd;
    e.port_a = i.rdat1;
    e.port_b = i.alusrc ? i.imm : i.rdat2;
    e.rt_dat = i.rdat2;
    return e;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic apply(input instr_t i);
    id_aluop = i.aluop; id_rs = i.rs; id_rt = i.rt; id_wsel = i.wsel;
    id_rdat1 = i.rdat1; id_rdat2 = i.rdat2; id_imm = i.imm;
    id_alusrc = i.alusrc; id_regwen = i.regwen; id_memrd = i.memrd;
  endtask

  // Present one instruction, queue its expectation, return just after the accepting edge.
  task automatic send(input instr_t i, input exp_t e);
    int  n = 0;
    bit  took = 1'b0;
    apply(i);
    in_valid = 1'b1;
    sb.push_back(e);
    while (!took && n < 50) begin
      @(negedge CLK);
      took = in_ready && !flush;
      tick();
      n++;
    end
    if (!took) check("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 1'b0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge CLK);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", sb.size(), 0);
      sb.delete();
    end
    tick();
  endtask

  always @(negedge CLK) begin
    if (nRST && ex_valid && ex_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_fire", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check("sb_port_a", port_a, mon_e.port_a);
        check("sb_port_b", port_b, mon_e.port_b);
        check("sb_rt_dat", ex_rt_dat, mon_e.rt_dat);
        check("sb_aluop", ex_aluop, mon_e.aluop);
        check("sb_wsel", ex_wsel, mon_e.wsel);
        check("sb_regwen", ex_regwen, mon_e.regwen);
        check("sb_memrd", ex_memrd, mon_e.memrd);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    instr_t ins, ins_b;
    exp_t   e;

    // Reset state
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;
    @(negedge CLK);
    check("rst_ex_valid", ex_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_port_a", port_a, 0);
    check("rst_aluop", ex_aluop, 0);
    check("rst_ex_regwen", ex_regwen, 0);
    tick();

    // Back-to-back throughput
    ex_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ins = mk(4'h2, 5'(i + 1), 5'(i + 9), 5'(i + 17), 32'h100 + i, 32'h200 + i,
               32'h300 + i, i[0], 1'b1, 1'b0);
      apply(ins);
      in_valid = 1'b1;
      sb.push_back(plain(ins));
      @(negedge CLK);
      check("tp_in_ready", in_ready, 1);
      check("tp_ex_valid", ex_valid, (i > 0));
      tick();
    end
    in_valid = 1'b0;
    @(negedge CLK);
    check("tp_last_valid", ex_valid, 1);
    tick();
    @(negedge CLK);
    check("tp_drain_valid", ex_valid, 0);
    tick();

    // Hold under backpressure, then fire and accept on the same edge
    ex_ready = 1'b0;
    ins = mk(4'h3, 5'd4, 5'd6, 5'd7, 32'hA1, 32'hA2, 32'hA3, 1'b0, 1'b1, 1'b0);
    send(ins, plain(ins));
    ins_b = mk(4'h6, 5'd11, 5'd12, 5'd13, 32'hB1, 32'hB2, 32'hB3, 1'b1, 1'b0, 1'b1);
    apply(ins_b);
    in_valid = 1'b1;
    sb.push_back(plain(ins_b));
    repeat (2) begin
      @(negedge CLK);
      check("hold_ex_valid", ex_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_port_a", port_a, 32'hA1);
      tick();
    end
    ex_ready = 1'b1;
    @(negedge CLK);
    check("swap_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    @(negedge CLK);
    check("swap_no_bubble", ex_valid, 1);
    drain();

    // Asynchronous reset while an instruction is held
    ex_ready = 1'b0;
    ins = mk(4'h4, 5'd2, 5'd3, 5'd4, 32'hC1, 32'hC2, 32'hC3, 1'b0, 1'b1, 1'b1);
    send(ins, plain(ins));
    @(negedge CLK);
    check("arst_pre_valid", ex_valid, 1);
    #2 nRST = 1'b0;
    #1;
    check("arst_ex_valid", ex_valid, 0);
    check("arst_port_a", port_a, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_aluop", ex_aluop, 0);
    sb.delete();
    @(posedge CLK);
    #1 nRST = 1'b1;
    ex_ready = 1'b1;
    tick();

`ifdef FWD_EN
    // EX/MEM wins over MEM/WB; register 0 never forwards
    exmem_regwen = 1'b1; exmem_wsel = 5'd5; exmem_wdat = 32'h22;
    memwb_regwen = 1'b1; memwb_wsel = 5'd5; memwb_wdat = 32'h33;
    ins = mk(4'h2, 5'd5, 5'd0, 5'd9, 32'h1, 32'h2, 32'h7, 1'b0, 1'b1, 1'b0);
    e = plain(ins);
    e.port_a = 32'h22;
    send(ins, e);
    ins.rs = 5'd0;
    send(ins, plain(ins));
    drain();

    memwb_wsel = 5'd6;
    ins = mk(4'h2, 5'd5, 5'd6, 5'd9, 32'h1, 32'h2, 32'h7, 1'b0, 1'b1, 1'b0);
    e = plain(ins);
    e.port_a = 32'h22; e.port_b = 32'h33; e.rt_dat = 32'h33;
    send(ins, e);
    drain();

    // Load-use: one bubble, then forwarded from MEM/WB
    exmem_regwen = 1'b1; exmem_memrd = 1'b1; exmem_wsel = 5'd8; exmem_wdat = 32'h77;
    memwb_regwen = 1'b0;
    ins = mk(4'h2, 5'd1, 5'd8, 5'd10, 32'h11, 32'h5, 32'h0, 1'b0, 1'b1, 1'b0);
    e = plain(ins);
    e.port_b = 32'hBEEF; e.rt_dat = 32'hBEEF;
    send(ins, e);
    @(negedge CLK);
    check("lu_ex_valid", ex_valid, 0);
    check("lu_in_ready", in_ready, 0);
    check("lu_ex_regwen", ex_regwen, 0);
    tick();
    exmem_regwen = 1'b0; exmem_memrd = 1'b0;
    memwb_regwen = 1'b1; memwb_wsel = 5'd8; memwb_wdat = 32'hBEEF;
    @(negedge CLK);
    check("lu_resume_valid", ex_valid, 1);
    drain();

    // Load with immediate address does not use rt, so no load-use stall
    memwb_regwen = 1'b0;
    exmem_regwen = 1'b1; exmem_memrd = 1'b1; exmem_wsel = 5'd8; exmem_wdat = 32'h77;
    ins = mk(4'h2, 5'd2, 5'd8, 5'd10, 32'h20, 32'h5, 32'h40, 1'b1, 1'b1, 1'b1);
    e = plain(ins);
    e.rt_dat = 32'h77;
    send(ins, e);
    @(negedge CLK);
    check("li_no_stall", ex_valid, 1);
    drain();
    exmem_regwen = 1'b0; exmem_memrd = 1'b0;
`else
    // rs=3 pending in EX/MEM one cycle, then MEM/WB one cycle: two stalls, then re-read value
    exmem_regwen = 1'b1; exmem_wsel = 5'd3;
    memwb_regwen = 1'b0;
    ins = mk(4'h2, 5'd3, 5'd0, 5'd9, 32'h111, 32'h2, 32'h7, 1'b0, 1'b1, 1'b0);
    e = plain(ins);
    e.port_a = 32'h999;
    send(ins, e);
    @(negedge CLK);
    check("st1_ex_valid", ex_valid, 0);
    check("st1_in_ready", in_ready, 0);
    tick();
    exmem_regwen = 1'b0;
    memwb_regwen = 1'b1; memwb_wsel = 5'd3;
    id_rdat1 = 32'h999;
    @(negedge CLK);
    check("st2_ex_valid", ex_valid, 0);
    check("st2_ex_regwen", ex_regwen, 0);
    tick();
    memwb_regwen = 1'b0;
    @(negedge CLK);
    check("st_resume_valid", ex_valid, 1);
    drain();

    // rt pending in MEM/WB stalls, then the re-read rt value reaches port_b
    memwb_regwen = 1'b1; memwb_wsel = 5'd9;
    ins = mk(4'h5, 5'd1, 5'd9, 5'd2, 32'h10, 32'h20, 32'h30, 1'b0, 1'b1, 1'b0);
    e = plain(ins);
    e.port_b = 32'hABC; e.rt_dat = 32'hABC;
    send(ins, e);
    @(negedge CLK);
    check("rt_stall_valid", ex_valid, 0);
    id_rdat2 = 32'hABC;
    tick();
    memwb_regwen = 1'b0;
    @(negedge CLK);
    check("rt_resume_valid", ex_valid, 1);
    drain();

    // Load with immediate address does not use rt, so no stall
    exmem_regwen = 1'b1; exmem_memrd = 1'b1; exmem_wsel = 5'd8;
    ins = mk(4'h2, 5'd2, 5'd8, 5'd10, 32'h20, 32'h5, 32'h40, 1'b1, 1'b1, 1'b1);
    send(ins, plain(ins));
    @(negedge CLK);
    check("li_no_stall", ex_valid, 1);
    drain();

    // Register 0 never causes a stall
    exmem_memrd = 1'b0; exmem_wsel = 5'd0;
    ins = mk(4'h2, 5'd0, 5'd0, 5'd10, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    send(ins, plain(ins));
    @(negedge CLK);
    check("r0_no_stall", ex_valid, 1);
    drain();
    exmem_regwen = 1'b0;
`endif

    // Flush squashes the held instruction and drops the incoming one
    ex_ready = 1'b0;
    ins = mk(4'h7, 5'd1, 5'd2, 5'd3, 32'hD1, 32'hD2, 32'hD3, 1'b0, 1'b1, 1'b0);
    send(ins, plain(ins));
    ins_b = mk(4'h8, 5'd4, 5'd5, 5'd6, 32'hE1, 32'hE2, 32'hE3, 1'b0, 1'b1, 1'b1);
    apply(ins_b);
    in_valid = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge CLK);
    check("fl_ex_valid", ex_valid, 0);
    check("fl_ex_regwen", ex_regwen, 0);
    check("fl_in_ready", in_ready, 1);
    sb.delete();
    tick();

    // Flush on an empty stage still discards the offered instruction
    ex_ready = 1'b1;
    apply(ins_b);
    in_valid = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge CLK);
    check("fl_empty_valid", ex_valid, 0);
    check("fl_empty_memrd", ex_memrd, 0);
    repeat (3) tick();

    check("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
